// File: rtl/lcd_frame_out.sv
// Captures the controller's IRB frame writes and, on a done rising edge,
// streams the frame raster-order over valid/ready with sof/eol/eof markers and a checksum.
module lcd_frame_out #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int DW   = 8,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          irb_rw,
  input  logic [AW-1:0] irb_a,
  input  logic [DW-1:0] irb_d,
  input  logic          done_in,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic          frame_done,
  output logic [15:0]   checksum,
  output logic          miss_err,
  output logic          drop_err
);

  localparam int DEPTH = COLS * ROWS;
  localparam logic [DEPTH-1:0] ONE_HOT0 = DEPTH'(1);

  typedef enum logic [1:0] {
    CAPTURE,
    STREAM,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] mask;
  logic [DEPTH-1:0] mask_set;
  logic [AW-1:0]    idx;
  logic             done_d;
  logic             done_rise;
  logic             wr;
  logic             accept;
  logic             last;

  assign wr        = ~irb_rw;
  assign done_rise = done_in & ~done_d;
  assign accept    = pix_valid & pix_ready;
  assign last      = (idx == AW'(DEPTH - 1));
  assign mask_set  = wr ? (ONE_HOT0 << irb_a) : '0;

  // Frame storage is deliberately not reset; the mask alone says what is valid.
  always_ff @(posedge clk) begin
    if (state == CAPTURE && wr) begin
      mem[irb_a] <= irb_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CAPTURE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pix_valid  = 1'b0;
    pix_data   = '0;
    pix_sof    = 1'b0;
    pix_eol    = 1'b0;
    pix_eof    = 1'b0;
    frame_done = 1'b0;
    case (state)
      CAPTURE: begin
        if (done_rise) begin
          state_nx = STREAM;
        end
      end
      STREAM: begin
        pix_valid = 1'b1;
        pix_data  = mem[idx];
        pix_sof   = (idx == '0);
        pix_eol   = ((int'(idx) % COLS) == (COLS - 1));
        pix_eof   = last;
        if (pix_ready && last) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        frame_done = 1'b1;
        state_nx   = CAPTURE;
      end
      default: state_nx = CAPTURE;
    endcase
  end

  // The miss check includes a write landing on the same edge as the start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_d   <= 1'b0;
      mask     <= '0;
      idx      <= '0;
      checksum <= '0;
      miss_err <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      done_d <= done_in;
      case (state)
        CAPTURE: begin
          mask <= mask | mask_set;
          if (done_rise) begin
            idx      <= '0;
            checksum <= '0;
            miss_err <= ~&(mask | mask_set);
            drop_err <= 1'b0;
          end
        end
        STREAM: begin
          if (wr) begin
            drop_err <= 1'b1;
          end
          if (accept) begin
            checksum <= checksum + 16'(pix_data);
            idx      <= idx + 1'b1;
          end
        end
        FIN: begin
          mask <= '0;
          if (wr) begin
            drop_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_out.sv
// Directed bench for lcd_frame_out: a scenario table of whole frames plus
// hand-written sequences for same-edge writes, mid-stream reset and held done_in.
module tb_lcd_frame_out;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        irb_rw;
  logic [5:0]  irb_a;
  logic [7:0]  irb_d;
  logic        done_in;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;
  logic        frame_done;
  logic [15:0] checksum;
  logic        miss_err;
  logic        drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] shadow [N];

  typedef struct {
    string       tag;
    int          pattern;
    int          n_writes;
    int          ready_mode;
    bit          drop_write;
    logic [15:0] exp_cs;
    logic        exp_miss;
    logic        exp_drop;
  } scen_t;

  scen_t scen [4];

  lcd_frame_out #(.COLS(8), .ROWS(8), .DW(8), .AW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .irb_rw     (irb_rw),
    .irb_a      (irb_a),
    .irb_d      (irb_d),
    .done_in    (done_in),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .frame_done (frame_done),
    .checksum   (checksum),
    .miss_err   (miss_err),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int p, input int a);
    case (p)
      0:       return 8'(a * 3);
      1:       return 8'h80;
      2:       return 8'hFF;
      default: return 8'(a);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [5:0] a, input logic [7:0] d,
                               input logic done, input logic rdy);
    irb_rw    = rw;
    irb_a     = a;
    irb_d     = d;
    done_in   = done;
    pix_ready = rdy;
  endtask

  task automatic write_frame(input int p, input int first, input int count);
    for (int a = first; a < first + count; a++) begin
      @(negedge clk);
      applyStimulus(1'b0, 6'(a), pat(p, a), 1'b0, 1'b0);
      shadow[a] = pat(p, a);
    end
  endtask

  task automatic start_frame(input bit with_wr, input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    applyStimulus(~with_wr, a, d, 1'b1, 1'b0);
    if (with_wr) shadow[a] = d;
  endtask

  // Walks the stream against the shadow image; mode 1 toggles pix_ready every cycle.
  task automatic stream_frame(input string tag, input int mode, input bit drop, input bit hold_done,
                              input logic [15:0] exp_cs, input logic exp_miss, input logic exp_drop);
    int          exp_idx  = 0;
    logic [15:0] sum      = '0;
    bit          finished = 1'b0;
    logic        rdy;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      if (exp_idx < N) begin
        checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(pix_data), 32'(shadow[exp_idx]));
        checkOutput({tag, "_sof"}, 32'(pix_sof), 32'(exp_idx == 0));
        checkOutput({tag, "_eol"}, 32'(pix_eol), 32'((exp_idx % 8) == 7));
        checkOutput({tag, "_eof"}, 32'(pix_eof), 32'(exp_idx == N - 1));
        checkOutput({tag, "_fdone_low"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_run_cs"}, 32'(checksum), 32'(sum));
        if (cyc == 0) begin
          checkOutput({tag, "_miss_start"}, 32'(miss_err), 32'(exp_miss));
          checkOutput({tag, "_drop_start"}, 32'(drop_err), 32'd0);
        end
        rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        if (drop && cyc == 3) applyStimulus(1'b0, 6'd5, 8'h00, hold_done, rdy);
        else                  applyStimulus(1'b1, 6'd0, 8'h00, hold_done, rdy);
        if (rdy) begin
          sum += 16'(shadow[exp_idx]);
          exp_idx++;
        end
      end else begin
        checkOutput({tag, "_fdone"}, 32'(frame_done), 32'd1);
        checkOutput({tag, "_fin_valid"}, 32'(pix_valid), 32'd0);
        finished = 1'b1;
        applyStimulus(1'b1, 6'd0, 8'h00, hold_done, 1'b0);
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no frame_done, expected one within 300 cycles", tag);
    end
    @(negedge clk);
    checkOutput({tag, "_fdone_after"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_idle_valid"}, 32'(pix_valid), 32'd0);
    checkOutput({tag, "_cs"}, 32'(checksum), 32'(exp_cs));
    checkOutput({tag, "_cs_model"}, 32'(checksum), 32'(sum));
    checkOutput({tag, "_miss"}, 32'(miss_err), 32'(exp_miss));
    checkOutput({tag, "_drop"}, 32'(drop_err), 32'(exp_drop));
  endtask

  initial begin
    scen[0] = '{"ramp",       0, 64, 0, 1'b0, 16'd6048,  1'b0, 1'b0};
    scen[1] = '{"ramp_stall", 0, 64, 1, 1'b0, 16'd6048,  1'b0, 1'b0};
    scen[2] = '{"drop",       1, 64, 0, 1'b1, 16'd8192,  1'b0, 1'b1};
    scen[3] = '{"miss",       2, 63, 0, 1'b0, 16'd16193, 1'b1, 1'b0};

    reset = 1'b1;
    applyStimulus(1'b1, 6'd0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_data", 32'(pix_data), 32'd0);
    checkOutput("rst_flags", 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
    checkOutput("rst_fdone", 32'(frame_done), 32'd0);
    checkOutput("rst_cs", 32'(checksum), 32'd0);
    checkOutput("rst_errs", 32'({miss_err, drop_err}), 32'd0);
    reset = 1'b0;

    for (int s = 0; s < 4; s++) begin
      write_frame(scen[s].pattern, 0, scen[s].n_writes);
      start_frame(1'b0, 6'd0, 8'h00);
      stream_frame(scen[s].tag, scen[s].ready_mode, scen[s].drop_write, 1'b0,
                   scen[s].exp_cs, scen[s].exp_miss, scen[s].exp_drop);
    end

    // Address 0 written on the very edge that samples the done rising edge.
    write_frame(0, 1, 63);
    start_frame(1'b1, 6'd0, 8'h11);
    stream_frame("same_edge", 0, 1'b0, 1'b0, 16'd6065, 1'b0, 1'b0);

    // Reset asserted asynchronously once 20 pixels have been accepted.
    write_frame(0, 0, 64);
    start_frame(1'b0, 6'd0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 6'd0, 8'h00, 1'b0, 1'b1);
    end
    @(negedge clk);
    checkOutput("midrst_pre_valid", 32'(pix_valid), 32'd1);
    checkOutput("midrst_pre_data", 32'(pix_data), 32'd60);
    checkOutput("midrst_pre_cs", 32'(checksum), 32'd570);
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(pix_valid), 32'd0);
    checkOutput("midrst_data", 32'(pix_data), 32'd0);
    checkOutput("midrst_cs", 32'(checksum), 32'd0);
    checkOutput("midrst_fdone", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 6'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst_idle_valid", 32'(pix_valid), 32'd0);

    // Fresh frame after reset, with done_in left high through and past the stream.
    write_frame(3, 0, 64);
    start_frame(1'b0, 6'd0, 8'h00);
    stream_frame("post_rst", 0, 1'b0, 1'b1, 16'd2016, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("held_done_no_retrigger", 32'(pix_valid), 32'd0);
    end
    applyStimulus(1'b1, 6'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("held_done_cs_hold", 32'(checksum), 32'd2016);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_frame_out.md
Name: lcd_frame_out

Overview:
- Downstream consumer of the LCD controller's image-result-buffer (IRB) write port.
- Captures the 8x8, 8-bit processed frame as the controller writes it out, tracking which addresses were written.
- On the controller's done indication, streams the frame raster-order to a display/panel interface over a valid/ready handshake, with line/frame markers and a pixel checksum.

Parameters:
- COLS, 8, pixels per line
- ROWS, 8, lines per frame
- DW, 8, pixel width
- AW, 6, address width; COLS*ROWS must equal 2**AW

Ports:
- clk  in  1  clock; all state updates on rising edge (upstream drives on falling edge)
- reset  in  1  reset, asynchronous, active-high
- irb_rw  in  1  0 = write strobe from controller, 1 = idle
- irb_a  in  AW  write address
- irb_d  in  DW  write data
- done_in  in  1  controller frame-complete level
- pix_data  out  DW  streamed pixel
- pix_valid  out  1  pixel valid
- pix_ready  in  1  sink accepts pixel
- pix_sof  out  1  first pixel of frame (qualified by pix_valid)
- pix_eol  out  1  last pixel of a line (qualified by pix_valid)
- pix_eof  out  1  last pixel of frame (qualified by pix_valid)
- frame_done  out  1  one-cycle pulse after last pixel accepted
- checksum  out  16  sum of all pixels accepted in last/current frame
- miss_err  out  1  sticky: stream began with unwritten addresses
- drop_err  out  1  sticky: write arrived while streaming

Behaviour:
- Storage: 2**AW x DW array, not reset. 2**AW-bit written mask, reset to 0.
- FSM states: CAPTURE (reset state), STREAM, FIN.
- CAPTURE:
  - irb_rw==0 -> mem[irb_a] <= irb_d, mask[irb_a] <= 1.
  - done_in rising edge (registered done_d, reset 0) -> STREAM.
  - A write on the same edge as the transition is stored.
  - On the transition: idx <= 0; checksum <= 0; miss_err <= (mask != all ones); drop_err <= 0.
- STREAM:
  - pix_valid = 1; pix_data = mem[idx] (combinational); idx is AW bits.
  - Flags: pix_sof = (idx==0); pix_eol = (idx%COLS == COLS-1); pix_eof = (idx == 2**AW-1).
  - On pix_valid & pix_ready: checksum <= checksum + pix_data (zero-extended); idx <= idx+1.
  - If idx was last on that accepted cycle -> FIN.
  - Without pix_ready, all outputs hold stable (memory cannot change in STREAM).
  - irb_rw==0 in STREAM -> write discarded, drop_err <= 1.
- FIN (one cycle):
  - frame_done = 1; mask <= 0; -> CAPTURE.
  - A write in FIN is discarded and sets drop_err.
- Outside STREAM: pix_valid, pix_sof, pix_eol, pix_eof = 0; pix_data = 0.
- checksum:
  - Max 64*255 = 16320, so no overflow at default size.
  - Holds its value after FIN until the next STREAM entry.
- miss_err and drop_err: hold until next CAPTURE->STREAM transition (drop_err cleared there, miss_err reloaded).
- done_in held high across frames does not retrigger; a new rising edge is required.
- Reset mid-stream: immediate return to CAPTURE. Outputs on reset: pix_* = 0, frame_done = 0, checksum = 0, miss_err = 0, drop_err = 0, mask = 0, idx = 0. Memory contents retained but treated as unwritten.
- Latency:
  - First pixel is valid the cycle after done_in rising is sampled.
  - With pix_ready held high: 64 consecutive pixels, then frame_done on cycle 65.

Test Plan:
- Write mem[a] = a*3 for a=0..63, pulse done_in, pix_ready=1 -> pixels 0,3,...,189 in order over 64 cycles; sof on the first; eol at idx 7,15,...,63; eof at 63; frame_done next cycle; checksum = 6048; miss_err = 0.
- Same frame with pix_ready toggling 1/0 every cycle -> identical pixel sequence; pix_data/flags stable while stalled; checksum = 6048.
- Write only addresses 0..62 (all 0xFF), then done_in -> miss_err = 1 at stream start; 64 pixels still emitted (pixel 63 is the stale/prior value).
- Write during STREAM to address 5 with data 0x00 over a frame of all 0x80 -> pixel 5 still 0x80; drop_err = 1; checksum = 8192.
- Write addr 0 = 0x11 on the same edge as done_in rising is sampled -> first pixel = 0x11.
- Assert reset at pixel 20 of stream -> pix_valid = 0 immediately; checksum = 0; state CAPTURE; a subsequent full write + done_in produces a correct frame.
